// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared types and defaults for the shared serial pattern
//                detector. Holds the controller state enum and the default
//                pattern.
//                  state_t   - IDLE / STREAM / FLUSH controller states
//                  c_pat_w   - default pattern length in bits
//                  c_pat     - default pattern, MSB is the first bit received
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    // IDLE: arbitrate, STREAM: feed owner's bits, FLUSH: report and clear.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam int             c_pat_w = 4;
    localparam logic [3:0]     c_pat   = 4'b1101;

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_pattern_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pattern_fsm
//  Description : Bit-serial overlapping pattern detector. Keeps the last
//                PAT_W-1 accepted bits and flags when the incoming bit
//                completes PAT. A fill counter prevents the cleared history
//                from taking part in a match, so only bits of the current
//                packet are compared.
//  Ports       : clk      - clock, rising edge
//                rst      - synchronous reset, active low
//                in       - serial data bit
//                en       - bit is accepted this cycle
//                clr      - forget history (packet boundary)
//                match_o  - registered one-cycle match pulse
//                hit_o    - combinational: accepted bit completes PAT now
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_fsm
    import seq_det_pkg::*;
#(
    parameter int             PAT_W = c_pat_w,
    parameter logic [PAT_W-1:0] PAT = c_pat
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic en,
    input  logic clr,
    output logic match_o,
    output logic hit_o
);

    localparam int c_fill_w = $clog2(PAT_W + 1);

    logic [PAT_W-2:0]    r_hist;
    logic [c_fill_w-1:0] r_fill;
    logic                r_match;
    logic [PAT_W-1:0]    w_window;
    logic                w_hit;

    // Window as it would look after taking the current bit.
    assign w_window = {r_hist, in};
    assign w_hit    = en && (w_window == PAT) && (r_fill >= c_fill_w'(PAT_W - 1));

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else begin
            r_match <= w_hit;
            if (en) begin
                r_hist <= w_window[PAT_W-2:0];
                if (r_fill != c_fill_w'(PAT_W - 1)) begin
                    r_fill <= r_fill + 1'b1;
                end
            end
        end
    end

    assign match_o = r_match;
    assign hit_o   = w_hit;

endmodule : seq_pattern_fsm
`default_nettype wire

// File: rtl/seq_det_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_arbiter
//  Description : Round-robin scheduler that shares one serial pattern
//                detector between NCH bit streams, one packet at a time.
//                Reports every match and a saturating per-packet match count.
//                Optional stall timeout: define SEQ_ARB_TIMEOUT_EN.
//  Ports       : clk       - clock, rising edge
//                rst       - synchronous reset, active low
//                valid     - per-channel bit valid
//                bit_in    - per-channel serial data bit
//                last      - per-channel end-of-packet marker
//                ready     - per-channel accept
//                grant     - one-hot detector owner, 0 when idle
//                match     - pattern completed (1-cycle pulse)
//                match_ch  - channel that produced match
//                done      - packet closed (1-cycle pulse)
//                done_ch   - channel whose packet closed
//                done_cnt  - matches in that packet (saturating)
//                abort     - packet closed by stall timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_det_arbiter
    import seq_det_pkg::*;
#(
    parameter int               NCH     = 4,
    parameter int               PAT_W   = c_pat_w,
    parameter logic [PAT_W-1:0] PAT     = c_pat,
    parameter int               CNT_W   = 4,
    parameter int               TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           valid,
    input  logic [NCH-1:0]           bit_in,
    input  logic [NCH-1:0]           last,
    output logic [NCH-1:0]           ready,
    output logic [NCH-1:0]           grant,
    output logic                     match,
    output logic [$clog2(NCH)-1:0]   match_ch,
    output logic                     done,
    output logic [$clog2(NCH)-1:0]   done_ch,
    output logic [CNT_W-1:0]         done_cnt,
    output logic                     abort
);

    localparam int             c_chw = $clog2(NCH);
    localparam logic [NCH-1:0] c_one = {{(NCH-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [NCH-1:0]     r_grant;
    logic [NCH-1:0]     r_ready;
    logic [c_chw-1:0]   r_ptr;
    logic [c_chw-1:0]   r_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic [c_chw-1:0]   r_done_ch;
    logic [CNT_W-1:0]   r_done_cnt;
    logic               r_abort;
    logic [c_chw-1:0]   r_match_ch;

    logic               w_pick_ok;
    logic [c_chw-1:0]   w_pick;
    logic               w_accept;
    logic               w_bit;
    logic               w_last;
    logic               w_hit;
    logic               w_det_match;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_timeout;

    // ------------------------------------------------------------------
    // Round-robin pick: first requester after the pointer, wrapping.
    // Scanning from the far end lets the nearest requester win last.
    // ------------------------------------------------------------------
    always_comb begin
        int w_idx;
        w_idx     = 0;
        w_pick_ok = 1'b0;
        w_pick    = '0;
        for (int k = NCH; k >= 1; k--) begin
            w_idx = (int'(r_ptr) + k) % NCH;
            if (valid[w_idx]) begin
                w_pick_ok = 1'b1;
                w_pick    = c_chw'(w_idx);
            end
        end
    end

    // Only the owner's lines matter; everything else is ignored.
    assign w_accept = (r_state == STREAM) && valid[r_owner];
    assign w_bit    = bit_in[r_owner];
    assign w_last   = last[r_owner];

    // Count including the bit being accepted now, so a match on the final
    // bit lands in done_cnt.
    assign w_cnt_next = (w_hit && (r_cnt != {CNT_W{1'b1}})) ? r_cnt + 1'b1 : r_cnt;

    seq_pattern_fsm #(
        .PAT_W   (PAT_W),
        .PAT     (PAT)
    ) u_det (
        .clk     (clk),
        .rst     (rst),
        .in      (w_bit),
        .en      (w_accept),
        .clr     (r_state == FLUSH),
        .match_o (w_det_match),
        .hit_o   (w_hit)
    );

    // ------------------------------------------------------------------
    // Stall timeout (optional)
    // ------------------------------------------------------------------
`ifdef SEQ_ARB_TIMEOUT_EN
    localparam int c_stall_w = $clog2(TIMEOUT + 1);

    logic [c_stall_w-1:0] r_stall;

    // Fires on the TIMEOUT-th consecutive stalled STREAM cycle.
    assign w_timeout = (r_state == STREAM) && !valid[r_owner] &&
                       (r_stall == c_stall_w'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst || (r_state != STREAM) || valid[r_owner]) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_ready    <= '0;
            r_ptr      <= c_chw'(NCH - 1);
            r_owner    <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_done_ch  <= '0;
            r_done_cnt <= '0;
            r_abort    <= 1'b0;
            r_match_ch <= '0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_ok) begin
                        r_grant <= c_one << w_pick;
                        r_ready <= c_one << w_pick;
                        r_owner <= w_pick;
                        r_ptr   <= w_pick;
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_accept) begin
                        r_match_ch <= r_owner;
                        r_cnt      <= w_cnt_next;
                    end
                    if ((w_accept && w_last) || w_timeout) begin
                        r_state    <= FLUSH;
                        r_ready    <= '0;
                        r_done     <= 1'b1;
                        r_abort    <= w_timeout;
                        r_done_ch  <= r_owner;
                        r_done_cnt <= w_accept ? w_cnt_next : r_cnt;
                    end
                end
                FLUSH: begin
                    r_cnt   <= '0;
                    r_grant <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign grant    = r_grant;
    assign match    = w_det_match;
    assign match_ch = r_match_ch;
    assign done     = r_done;
    assign done_ch  = r_done_ch;
    assign done_cnt = r_done_cnt;
    assign abort    = r_abort;

endmodule : seq_det_arbiter
`default_nettype wire

// File: tb/tb_seq_det_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_det_arbiter
//  Description : Randomized self-checking bench for seq_det_arbiter. A
//                packet-level model predicts grants (round robin), matches
//                (pattern search over accepted bits) and packet reports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_arbiter;

    localparam int         NCH     = 4;
    localparam int         CHW     = 2;
    localparam int         CNT_W   = 4;
    localparam int         TIMEOUT = 16;
    localparam logic [3:0] PAT     = 4'b1101;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NCH-1:0] valid = '0;
    logic [NCH-1:0] bit_in = '0;
    logic [NCH-1:0] last = '0;
    logic [NCH-1:0] ready;
    logic [NCH-1:0] grant;
    logic           match;
    logic [CHW-1:0] match_ch;
    logic           done;
    logic [CHW-1:0] done_ch;
    logic [CNT_W-1:0] done_cnt;
    logic           abort;

    always #5 clk = ~clk;

    seq_det_arbiter #(
        .NCH(NCH), .PAT_W(4), .PAT(PAT), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .valid(valid), .bit_in(bit_in), .last(last),
        .ready(ready), .grant(grant), .match(match), .match_ch(match_ch),
        .done(done), .done_ch(done_ch), .done_cnt(done_cnt), .abort(abort)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    bit             qb[NCH][$];   // bits waiting to be sent, per channel
    bit             ql[NCH][$];   // matching end-of-packet markers
    bit             acc[NCH][$];  // bits of the open packet already accepted
    int             own = -1;     // owner during the cycle just checked
    bit             prev_done = 1'b0;
    logic [NCH-1:0] p_valid = '0;
    int             rr_last = NCH - 1;
    bit             a_hit = 1'b0, a_end = 1'b0, a_to = 1'b0;
    int             a_ch = 0, a_cnt = 0, hits = 0, stall = 0;
    logic [3:0]     pat_v = PAT;

    task automatic add_bits(input int ch, input logic [31:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            qb[ch].push_back(bits[i]);
            ql[ch].push_back(i == 0);
        end
    endtask

    task automatic add_rand(input int ch);
        int len;
        logic [31:0] b;
        len = $urandom_range(1, 12);
        b   = '0;
        for (int i = 0; i < len; i++) b[i] = ($urandom_range(0, 99) < 65);
        add_bits(ch, b, len);
    endtask

    // Discard the rest of a packet the DUT will never finish.
    task automatic drop_pkt(input int ch);
        bit l;
        while (qb[ch].size() > 0) begin
            void'(qb[ch].pop_front());
            l = ql[ch].pop_front();
            if (l) break;
        end
    endtask

    function automatic bit busy();
        bit b;
        b = (own >= 0);
        for (int c = 0; c < NCH; c++) if (qb[c].size() > 0) b = 1'b1;
        return b;
    endfunction

    // One clock: check what the last edge produced, then drive this cycle.
    task automatic step(input int vprob, input bit long_stall);
        int g, n;
        bit d;
        logic [NCH-1:0] v, eg, er;
        @(negedge clk);
        if (own < 0) begin
            g = -1;
            for (int k = 1; k <= NCH && g < 0; k++)
                if (p_valid[(rr_last + k) % NCH]) g = (rr_last + k) % NCH;
            if (g >= 0) rr_last = g;
        end else if (prev_done) begin
            g = -1;
        end else begin
            g = own;
        end
        d  = a_end || a_to;
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        er = (g >= 0 && !d) ? eg : '0;
        check("grant", 32'(grant), 32'(eg));
        check("ready", 32'(ready), 32'(er));
        check("match", 32'(match), 32'(a_hit));
        if (a_hit) check("match_ch", 32'(match_ch), 32'(a_ch));
        check("done", 32'(done), 32'(d));
        check("abort", 32'(abort), 32'(a_to));
        if (d) begin
            check("done_ch", 32'(done_ch), 32'(own));
            check("done_cnt", 32'(done_cnt), 32'(a_cnt));
        end
        own = g;
        prev_done = d;

        a_hit = 1'b0; a_end = 1'b0; a_to = 1'b0;
        for (int c = 0; c < NCH; c++)
            v[c] = (qb[c].size() > 0) && ($urandom_range(0, 99) < vprob);
        if (own >= 0 && !d && !long_stall && stall >= 8) v[own] = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            bit_in[c] = v[c] ? qb[c][0] : 1'($urandom);
            last[c]   = v[c] ? ql[c][0] : 1'($urandom);
        end
        valid = v;

        if (own >= 0 && !d) begin
            if (v[own]) begin
                acc[own].push_back(qb[own].pop_front());
                a_end = ql[own].pop_front();
                stall = 0;
                a_ch  = own;
                n     = acc[own].size();
                if (n >= 4) begin
                    a_hit = 1'b1;
                    for (int j = 0; j < 4; j++)
                        if (acc[own][n - 4 + j] != pat_v[3 - j]) a_hit = 1'b0;
                end
                if (a_hit) hits++;
            end else begin
                stall++;
`ifdef SEQ_ARB_TIMEOUT_EN
                if (stall == TIMEOUT) begin
                    a_to = 1'b1;
                    drop_pkt(own);
                end
`endif
            end
            if (a_end || a_to) begin
                a_cnt = (hits > 15) ? 15 : hits;
                hits  = 0;
                stall = 0;
                acc[own].delete();
            end
        end
        p_valid = v;
    endtask

    task automatic run(input int vprob);
        int guard;
        guard = 0;
        while (busy() && guard < 400) begin
            step(vprob, 1'b0);
            guard++;
        end
        check("drain_bound", 32'(busy()), 32'd0);
        step(vprob, 1'b0);
        step(vprob, 1'b0);
    endtask

    // Step until channel ch has had k bits of its open packet accepted.
    task automatic feed_until(input int ch, input int k);
        int guard;
        guard = 0;
        while (!(own == ch && acc[ch].size() == k && !a_end) && guard < 100) begin
            step(100, 1'b0);
            guard++;
        end
        check("feed_bound", 32'(guard < 100), 32'd1);
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        valid = '0;
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        rst = 1'b1;
        if (own >= 0 && !prev_done && !a_end && !a_to) drop_pkt(own);
        for (int c = 0; c < NCH; c++) acc[c].delete();
        own = -1; prev_done = 1'b0; p_valid = '0; rr_last = NCH - 1;
        a_hit = 1'b0; a_end = 1'b0; a_to = 1'b0; hits = 0; stall = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Packet with two overlapping matches.
        add_bits(0, 32'b1101101, 7);
        run(100);

        // Two requesters from reset: ch0 then ch2, then ch0 again.
        do_reset();
        add_bits(0, 32'b1011, 4); add_bits(2, 32'b0110, 4);
        add_bits(0, 32'b1101, 4); add_bits(2, 32'b11101, 5);
        run(100);

        // Stalls inside a packet do not disturb the detector.
        add_bits(1, 32'b1101, 4);
        feed_until(1, 2);
        repeat (3) step(0, 1'b1);
        run(100);

        // No match across a packet boundary.
        add_bits(3, 32'b110, 3); add_bits(3, 32'b1001, 4);
        run(100);

        // Reset in the middle of a packet.
        add_bits(0, 32'b11011011, 8); add_bits(0, 32'b01101, 5);
        add_bits(1, 32'b1101, 4); add_bits(2, 32'b111, 3);
        feed_until(0, 3);
        do_reset();
        run(100);

        // Long stall: timeout closes the packet only when enabled.
        add_bits(1, 32'b110111, 6);
        feed_until(1, 2);
        repeat (20) step(0, 1'b1);
        run(100);

        // Random traffic.
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 99) < 12) begin
                int c;
                c = $urandom_range(0, NCH - 1);
                if (qb[c].size() == 0) add_rand(c);
            end
            step(75, 1'b0);
        end
        run(75);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_seq_det_arbiter
`default_nettype wire
